axis_i2c_target: RTL and testbench

I2C target (slave) with AXI-Stream interfaces. It is the responder counterpart to the team's AXIS I2C master and is used as the in-system loopback partner and bench model. It oversamples SCL/SDA on the system clock, decodes START/STOP, matches a 7-bit address, and handles bytes in both directions:
- Bytes written by the bus master leave on `m_axis`.
- Bytes read by the bus master are taken from `s_axis`; SCL is stretched while no data is available.

---
 rtl/i2c_pkg.sv | 21 ++
 rtl/i2c_sync_edge.sv | 31 +++
 rtl/axis_i2c_target.sv | 220 ++++++++++++++++++++++
 tb/tb_axis_i2c_target.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_pkg.sv
// Shared definitions for the AXI-Stream I2C master/target pair:
// target FSM states, byte width and R/W bit encodings.
package i2c_pkg;

    localparam int   I2C_BYTE_W   = 8;
    localparam logic I2C_RW_WRITE = 1'b0;
    localparam logic I2C_RW_READ  = 1'b1;

    typedef enum logic [3:0] {
        S_IDLE,
        S_ADDR,
        S_ADDR_ACK,
        S_WR_DATA,
        S_WR_ACK,
        S_RD_LOAD,
        S_RD_DATA,
        S_RD_ACK,
        S_IGNORE
    } i2c_tgt_state_t;

endpackage

// File: rtl/i2c_sync_edge.sv
// Multi-stage synchronizer for one I2C line with rise/fall detection.
// Flops reset to 1 because an idle bus line is pulled high.
module i2c_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic line,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] chain;
    logic                   prev;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            chain <= '1;
            prev  <= 1'b1;
        end else begin
            chain <= {chain[SYNC_STAGES-2:0], line};
            prev  <= chain[SYNC_STAGES-1];
        end
    end

    assign level = chain[SYNC_STAGES-1];
    assign rise  = level & ~prev;
    assign fall  = ~level & prev;

endmodule

// File: rtl/axis_i2c_target.sv
// I2C target: written bytes leave on m_axis, read bytes are popped from s_axis,
// and SCL is stretched while the transmit stream has nothing to offer.
module axis_i2c_target #(
    parameter logic [6:0] ADDR        = 7'h50,
    parameter int         SYNC_STAGES = 2
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       scl_i,
    input  logic       sda_i,
    output logic       scl_oe_o,
    output logic       sda_oe_o,
    output logic [7:0] m_axis_tdata,
    output logic       m_axis_tvalid,
    input  logic       m_axis_tready,
    output logic       m_axis_tuser,
    input  logic [7:0] s_axis_tdata,
    input  logic       s_axis_tvalid,
    output logic       s_axis_tready,
    output logic       busy_o
);
    import i2c_pkg::*;

    i2c_tgt_state_t        state, state_n;
    logic [3:0]            bit_cnt, cnt_n;
    logic [I2C_BYTE_W-1:0] shift, shift_n, rx_byte, m_data, m_data_n;
    logic                  rw, rw_n, ack, ack_n, first, first_n;
    logic                  scl_oe, scl_oe_n, sda_oe, sda_oe_n;
    logic                  m_valid, m_valid_n, m_user, m_user_n;
    logic                  s_ready, s_ready_n, busy, busy_n;
    logic                  scl, scl_rise, scl_fall, sda, sda_rise, sda_fall;
    logic                  start, stop;

    i2c_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_scl_sync (
        .clk(clk_i), .rst(rst_i), .line(scl_i),
        .level(scl), .rise(scl_rise), .fall(scl_fall)
    );

    i2c_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sda_sync (
        .clk(clk_i), .rst(rst_i), .line(sda_i),
        .level(sda), .rise(sda_rise), .fall(sda_fall)
    );

    assign start   = sda_fall & scl;
    assign stop    = sda_rise & scl;
    assign rx_byte = {shift[I2C_BYTE_W-2:0], sda};

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state   <= S_IDLE;
            bit_cnt <= 4'd0;
            shift   <= '0;
            rw      <= 1'b0;
            ack     <= 1'b0;
            first   <= 1'b0;
            scl_oe  <= 1'b0;
            sda_oe  <= 1'b0;
            m_data  <= '0;
            m_valid <= 1'b0;
            m_user  <= 1'b0;
            s_ready <= 1'b0;
            busy    <= 1'b0;
        end else begin
            state   <= state_n;
            bit_cnt <= cnt_n;
            shift   <= shift_n;
            rw      <= rw_n;
            ack     <= ack_n;
            first   <= first_n;
            scl_oe  <= scl_oe_n;
            sda_oe  <= sda_oe_n;
            m_data  <= m_data_n;
            m_valid <= m_valid_n;
            m_user  <= m_user_n;
            s_ready <= s_ready_n;
            busy    <= busy_n;
        end
    end

    always_comb begin
        state_n   = state;
        cnt_n     = bit_cnt;
        shift_n   = shift;
        rw_n      = rw;
        ack_n     = ack;
        first_n   = first;
        scl_oe_n  = scl_oe;
        sda_oe_n  = sda_oe;
        m_data_n  = m_data;
        m_valid_n = m_valid;
        m_user_n  = m_user;
        s_ready_n = 1'b0;
        busy_n    = busy;

        if (m_valid && m_axis_tready) begin
            m_valid_n = 1'b0;
            m_user_n  = 1'b0;
        end

        if (stop) begin
            state_n  = S_IDLE;
            scl_oe_n = 1'b0;
            sda_oe_n = 1'b0;
            busy_n   = 1'b0;
        end else if (start) begin
            state_n  = S_ADDR;
            cnt_n    = 4'd0;
            scl_oe_n = 1'b0;
            sda_oe_n = 1'b0;
        end else begin
            case (state)
                S_ADDR: begin
                    if (scl_rise) begin
                        shift_n = rx_byte;
                        cnt_n   = bit_cnt + 4'd1;
                        if (bit_cnt == 4'd7) begin
                            cnt_n = 4'd0;
                            if (rx_byte[7:1] == ADDR) begin
                                state_n = S_ADDR_ACK;
                                busy_n  = 1'b1;
                                rw_n    = rx_byte[0];
                                first_n = 1'b1;
                            end else begin
                                state_n = S_IGNORE;
                            end
                        end
                    end
                end
                // ACK phases: bit_cnt 0 = before the 9th rise, 1 = after it
                S_ADDR_ACK: begin
                    if (scl_fall && bit_cnt == 4'd0) begin
                        sda_oe_n = 1'b1;
                    end else if (scl_fall) begin
                        sda_oe_n = 1'b0;
                        cnt_n    = 4'd0;
                        state_n  = (rw == I2C_RW_WRITE) ? S_WR_DATA : S_RD_LOAD;
                    end else if (scl_rise) begin
                        cnt_n = 4'd1;
                    end
                end
                S_WR_DATA: begin
                    if (scl_rise) begin
                        shift_n = rx_byte;
                        cnt_n   = bit_cnt + 4'd1;
                        if (bit_cnt == 4'd7) begin
                            cnt_n   = 4'd0;
                            state_n = S_WR_ACK;
                            ack_n   = 1'b0;
                            if (!m_valid || m_axis_tready) begin
                                m_data_n  = rx_byte;
                                m_valid_n = 1'b1;
                                m_user_n  = first;
                                first_n   = 1'b0;
                                ack_n     = 1'b1;
                            end
                        end
                    end
                end
                S_WR_ACK: begin
                    if (scl_fall && bit_cnt == 4'd0) begin
                        sda_oe_n = ack;
                    end else if (scl_fall) begin
                        sda_oe_n = 1'b0;
                        cnt_n    = 4'd0;
                        state_n  = S_WR_DATA;
                    end else if (scl_rise) begin
                        cnt_n = 4'd1;
                    end
                end
                // Stretch only while nothing is offered; the pop cycle keeps the current hold
                S_RD_LOAD: begin
                    if (s_ready) begin
                        shift_n  = s_axis_tdata;
                        sda_oe_n = ~s_axis_tdata[7];
                        scl_oe_n = 1'b0;
                        cnt_n    = 4'd0;
                        state_n  = S_RD_DATA;
                    end else if (s_axis_tvalid) begin
                        s_ready_n = 1'b1;
                    end else begin
                        scl_oe_n = 1'b1;
                    end
                end
                S_RD_DATA: begin
                    if (scl_rise) begin
                        cnt_n = bit_cnt + 4'd1;
                    end else if (scl_fall && bit_cnt == 4'd8) begin
                        sda_oe_n = 1'b0;
                        cnt_n    = 4'd0;
                        state_n  = S_RD_ACK;
                    end else if (scl_fall) begin
                        shift_n  = {shift[I2C_BYTE_W-2:0], 1'b0};
                        sda_oe_n = ~shift[I2C_BYTE_W-2];
                    end
                end
                S_RD_ACK: begin
                    if (scl_rise) begin
                        if (sda) state_n = S_IGNORE;
                        else     cnt_n   = 4'd1;
                    end else if (scl_fall && bit_cnt == 4'd1) begin
                        cnt_n   = 4'd0;
                        state_n = S_RD_LOAD;
                    end
                end
                S_IDLE, S_IGNORE: begin
                end
                default: state_n = S_IDLE;
            endcase
        end
    end

    assign scl_oe_o      = scl_oe;
    assign sda_oe_o      = sda_oe;
    assign m_axis_tdata  = m_data;
    assign m_axis_tvalid = m_valid;
    assign m_axis_tuser  = m_user;
    assign s_axis_tready = s_ready;
    assign busy_o        = busy;

endmodule

// File: tb/tb_axis_i2c_target.sv
// Bench for axis_i2c_target: a bit-level I2C master model drives the open-drain bus,
// m_axis beats are checked against a scoreboard queue by a forked monitor.
module tb_axis_i2c_target;
    import i2c_pkg::*;

    localparam int         H   = 12;
    localparam logic [6:0] TGT = 7'h50;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       scl_drv = 1'b1, sda_drv = 1'b1;
    logic       scl_bus, sda_bus, scl_oe, sda_oe;
    logic [7:0] m_tdata;
    logic       m_tvalid, m_tuser;
    logic       m_tready = 1'b1;
    logic [7:0] s_tdata = 8'h00;
    logic       s_tvalid = 1'b0;
    logic       s_tready, busy;

    int         n_checks = 0, n_fail = 0;
    int         pulses = 0, wide = 0, sda_drive_cycles = 0;
    logic       prev_ready = 1'b0;
    logic [8:0] exp_q[$];
    logic [7:0] tx_q[$];

    assign scl_bus = scl_drv & ~scl_oe;
    assign sda_bus = sda_drv & ~sda_oe;

    always #5 clk = ~clk;

    axis_i2c_target #(.ADDR(TGT), .SYNC_STAGES(2)) dut (
        .clk_i(clk), .rst_i(rst), .scl_i(scl_bus), .sda_i(sda_bus),
        .scl_oe_o(scl_oe), .sda_oe_o(sda_oe),
        .m_axis_tdata(m_tdata), .m_axis_tvalid(m_tvalid),
        .m_axis_tready(m_tready), .m_axis_tuser(m_tuser),
        .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid),
        .s_axis_tready(s_tready), .busy_o(busy)
    );

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got 'h%0h, expected 'h%0h", name, act, exp);
        end
    endtask

    task automatic wait_clks(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic monitor_loop();
        logic [8:0] e;
        forever begin
            @(negedge clk);
            if (s_tready) begin
                if (prev_ready) wide++;
                else pulses++;
            end
            prev_ready = s_tready;
            if (sda_oe) sda_drive_cycles++;
            if (!rst && m_tvalid && m_tready) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("[TB] FAIL m_axis_unexpected: got tuser=%0b tdata='h%0h, expected no beat", m_tuser, m_tdata);
                end else begin
                    e = exp_q.pop_front();
                    check_output("m_axis_beat", {23'd0, m_tuser, m_tdata}, {23'd0, e});
                end
            end
        end
    endtask

    task automatic source_loop();
        logic hs;
        forever begin
            @(negedge clk);
            hs = s_tvalid && s_tready;
            @(posedge clk);
            #1;
            if (hs && tx_q.size() > 0) void'(tx_q.pop_front());
            s_tvalid = (tx_q.size() > 0);
            s_tdata  = (tx_q.size() > 0) ? tx_q[0] : 8'h00;
        end
    endtask

    task automatic release_scl();
        int t;
        t = 0;
        scl_drv = 1'b1;
        while (scl_bus !== 1'b1 && t < 2000) begin
            wait_clks(1);
            t++;
        end
        if (t >= 2000) begin
            n_checks++;
            n_fail++;
            $display("[TB] FAIL scl_release_timeout: got scl low for %0d clocks, expected release", t);
        end
    endtask

    task automatic xfer_bit(input logic b, output logic s);
        wait_clks(4);
        sda_drv = b;
        wait_clks(H - 4);
        release_scl();
        wait_clks(H / 2);
        s = sda_bus;
        wait_clks(H / 2);
        scl_drv = 1'b0;
    endtask

    task automatic i2c_start();
        sda_drv = 1'b1;
        wait_clks(H);
        release_scl();
        wait_clks(H);
        sda_drv = 1'b0;
        wait_clks(H);
        scl_drv = 1'b0;
        wait_clks(2);
    endtask

    task automatic i2c_stop();
        sda_drv = 1'b0;
        wait_clks(H);
        release_scl();
        wait_clks(H);
        sda_drv = 1'b1;
        wait_clks(H);
    endtask

    task automatic write_byte(input logic [7:0] d, output logic ack);
        logic s;
        for (int i = 7; i >= 0; i--) xfer_bit(d[i], s);
        xfer_bit(1'b1, ack);
    endtask

    task automatic read_byte(input logic nack, output logic [7:0] d);
        logic s;
        for (int i = 7; i >= 0; i--) begin
            xfer_bit(1'b1, s);
            d[i] = s;
        end
        xfer_bit(nack, s);
    endtask

    task automatic apply_stimulus();
        logic       ack, s;
        logic [7:0] got;
        int         base, t, low_miss;

        // Write 0x3C after address 0x50/W
        i2c_start();
        write_byte({TGT, I2C_RW_WRITE}, ack);
        check_output("t1_addr_ack", ack, 0);
        check_output("t1_busy_set", busy, 1);
        exp_q.push_back({1'b1, 8'h3C});
        write_byte(8'h3C, ack);
        check_output("t1_data_ack", ack, 0);
        i2c_stop();
        wait_clks(4);
        check_output("t1_busy_clear", busy, 0);

        // Foreign address 0x51 must be ignored silently
        base = sda_drive_cycles;
        i2c_start();
        write_byte(8'hA2, ack);
        check_output("t2_addr_nack", ack, 1);
        i2c_stop();
        wait_clks(4);
        check_output("t2_sda_never_driven", sda_drive_cycles - base, 0);
        check_output("t2_busy", busy, 0);

        // Two-byte read, master NACKs the last one
        base = pulses;
        tx_q.push_back(8'hA5);
        tx_q.push_back(8'h5A);
        i2c_start();
        write_byte({TGT, I2C_RW_READ}, ack);
        check_output("t3_addr_ack", ack, 0);
        read_byte(1'b0, got);
        check_output("t3_byte0", got, 8'hA5);
        read_byte(1'b1, got);
        check_output("t3_byte1", got, 8'h5A);
        i2c_stop();
        wait_clks(4);
        check_output("t3_pop_count", pulses - base, 2);

        // Read with an empty s_axis: SCL stretched until the byte shows up
        i2c_start();
        write_byte({TGT, I2C_RW_READ}, ack);
        check_output("t4_addr_ack", ack, 0);
        got = 8'h00;
        fork
            read_byte(1'b1, got);
            begin
                wait_clks(20);
                check_output("t4_stretch_start", scl_oe, 1);
                low_miss = 0;
                for (int i = 0; i < 200; i++) begin
                    wait_clks(1);
                    if (scl_oe !== 1'b1) low_miss++;
                end
                check_output("t4_stretch_held", low_miss, 0);
                tx_q.push_back(8'h96);
                t = 0;
                while (s_tready !== 1'b1 && t < 50) begin
                    wait_clks(1);
                    t++;
                end
                check_output("t4_pop_seen", s_tready, 1);
                check_output("t4_scl_held_at_pop", scl_oe, 1);
                wait_clks(1);
                check_output("t4_scl_released", scl_oe, 0);
                check_output("t4_tready_width", s_tready, 0);
            end
        join
        check_output("t4_byte", got, 8'h96);
        i2c_stop();

        // m_axis back-pressure: first byte held, second dropped with NACK
        m_tready = 1'b0;
        i2c_start();
        write_byte({TGT, I2C_RW_WRITE}, ack);
        check_output("t5_addr_ack", ack, 0);
        exp_q.push_back({1'b1, 8'h11});
        write_byte(8'h11, ack);
        check_output("t5_first_ack", ack, 0);
        write_byte(8'h22, ack);
        check_output("t5_second_nack", ack, 1);
        i2c_stop();
        check_output("t5_held_valid", m_tvalid, 1);
        check_output("t5_held_data", m_tdata, 8'h11);
        m_tready = 1'b1;
        wait_clks(4);
        check_output("t5_drained", m_tvalid, 0);

        // Repeated START mid-byte, then reset while the target drives SDA
        m_tready = 1'b0;
        i2c_start();
        write_byte({TGT, I2C_RW_WRITE}, ack);
        check_output("t6_addr_ack", ack, 0);
        exp_q.push_back({1'b1, 8'h77});
        write_byte(8'h77, ack);
        check_output("t6_data_ack", ack, 0);
        for (int i = 0; i < 4; i++) xfer_bit(1'b1, s);
        i2c_start();
        tx_q.push_back(8'h00);
        write_byte({TGT, I2C_RW_READ}, ack);
        check_output("t6_restart_addr_ack", ack, 0);
        t = 0;
        while (sda_oe !== 1'b1 && t < 100) begin
            wait_clks(1);
            t++;
        end
        check_output("t6_driving_before_reset", sda_oe, 1);
        check_output("t6_m_held_before_reset", m_tvalid, 1);
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check_output("t6_rst_scl_oe", scl_oe, 0);
        check_output("t6_rst_sda_oe", sda_oe, 0);
        check_output("t6_rst_m_empty", m_tvalid, 0);
        check_output("t6_rst_busy", busy, 0);
        exp_q.delete();
        wait_clks(3);
        rst = 1'b0;
        m_tready = 1'b1;
        wait_clks(4);
        i2c_stop();
        wait_clks(4);
        check_output("t6_final_busy", busy, 0);
    endtask

    initial begin
        fork
            monitor_loop();
            source_loop();
        join_none
        wait_clks(5);
        check_output("rst_scl_oe", scl_oe, 0);
        check_output("rst_sda_oe", sda_oe, 0);
        check_output("rst_m_tvalid", m_tvalid, 0);
        check_output("rst_m_tuser", m_tuser, 0);
        check_output("rst_m_tdata", m_tdata, 8'h00);
        check_output("rst_s_tready", s_tready, 0);
        check_output("rst_busy", busy, 0);
        rst = 1'b0;
        wait_clks(5);
        apply_stimulus();
        wait_clks(10);
        check_output("scoreboard_empty", exp_q.size(), 0);
        check_output("tready_never_wide", wide, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #600000;
        $display("[TB] FAIL watchdog: got no finish after 60000 clocks, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
